zbuf_arbiter: RTL and testbench

Sequencer that shares the single-port depth memory between two fragment requesters (rasterizer channels 1 and 2) and runs the depth test for each fragment: read stored Z, compare, conditionally write. It also runs a full-buffer clear to Z_MAX on command. It sits between the rasterizer FSM/initiator pair and the depth RAM.

---
 rtl/zbuf_arbiter_if.sv | 30 +++
 rtl/zbuf_arbiter.sv | 138 +++++++++++++
 tb/tb_zbuf_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/zbuf_arbiter_if.sv
// Fragment-requester and depth-RAM signal bundle for zbuf_arbiter.
// The arbiter owns the master modport; requesters and the RAM sit on the slave side.
interface zbuf_arbiter_if #(
  parameter int COORD_W = 8,
  parameter int Z_W     = 8
);
  logic                     req_1;
  logic [2*COORD_W+Z_W-1:0] pt_1;
  logic                     ack_1;
  logic                     pass_1;
  logic                     req_2;
  logic [2*COORD_W+Z_W-1:0] pt_2;
  logic                     ack_2;
  logic                     pass_2;
  logic [2*COORD_W-1:0]     mem_addr;
  logic                     mem_rd;
  logic [Z_W-1:0]           mem_rdata;
  logic                     mem_wr;
  logic [Z_W-1:0]           mem_wdata;

  modport master (
    input  req_1, pt_1, req_2, pt_2, mem_rdata,
    output ack_1, pass_1, ack_2, pass_2, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    output req_1, pt_1, req_2, pt_2, mem_rdata,
    input  ack_1, pass_1, ack_2, pass_2, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/zbuf_arbiter.sv
// Depth-buffer sequencer: round-robin arbitration of two fragment requesters,
// read/compare/conditional-write depth test, and full-buffer clear to Z_MAX.
module zbuf_arbiter #(
  parameter int             COORD_W = 8,
  parameter int             Z_W     = 8,
  parameter logic [Z_W-1:0] Z_MAX   = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  zbuf_arbiter_if.master       bus,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic [15:0]          pass_cnt
);
  localparam int PT_W = 2*COORD_W + Z_W;
  localparam int A_W  = 2*COORD_W;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_WR, S_ACK, S_CLR} state_t;

  state_t          state_q, state_d;
  logic [PT_W-1:0] pt_q, pt_d;
  logic            gnt_q, gnt_d;    // 0: requester 1, 1: requester 2
  logic            last_q, last_d;  // requester granted most recently
  logic            ack_q, ack_d;
  logic            pass_q, pass_d;
  logic            pend_q, pend_d;
  logic [A_W-1:0]  addr_q, addr_d;
  logic [Z_W-1:0]  wdata_q, wdata_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            grant;
  logic            req_g;
  logic [PT_W-1:0] sel_pt;
  logic [Z_W-1:0]  z_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pt_q    <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= 1'b0;
      pass_q  <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      pass_q  <= pass_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z_q = pt_q[Z_W-1:0];

  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ack_d   = ack_q;
    pass_d  = pass_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    grant   = (bus.req_1 && bus.req_2) ? ~last_q : bus.req_2;
    sel_pt  = grant ? bus.pt_2 : bus.pt_1;
    req_g   = gnt_q ? bus.req_2 : bus.req_1;

    if (clr_start && state_q != S_CLR) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_CLR;
          pend_d  = 1'b0;
          addr_d  = '0;
          wdata_d = Z_MAX;
        end else if (bus.req_1 || bus.req_2) begin
          state_d = S_RD;
          gnt_d   = grant;
          last_d  = grant;
          pt_d    = sel_pt;
          addr_d  = {sel_pt[COORD_W+Z_W-1 -: COORD_W], sel_pt[PT_W-1 -: COORD_W]};
        end
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        if (z_q < bus.mem_rdata) begin
          state_d = S_WR;
          wdata_d = z_q;
        end else begin
          state_d = S_ACK;
          pass_d  = 1'b0;
        end
      end
      S_WR: begin
        state_d = S_ACK;
        pass_d  = 1'b1;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
      S_ACK: begin
        // ack is registered one cycle into ACK and released once req drops
        if (req_g) begin
          ack_d = 1'b1;
        end else begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ack_1     = ack_q & ~gnt_q;
  assign bus.ack_2     = ack_q & gnt_q;
  assign bus.pass_1    = ack_q & ~gnt_q & pass_q;
  assign bus.pass_2    = ack_q & gnt_q & pass_q;
  assign bus.mem_rd    = (state_q == S_RD);
  assign bus.mem_wr    = (state_q == S_WR) || (state_q == S_CLR);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign clr_busy      = pend_q || (state_q == S_CLR);
  assign pass_cnt      = cnt_q;
endmodule

// File: tb/tb_zbuf_arbiter.sv
// Randomized and directed bench for zbuf_arbiter against a per-fragment depth
// model (shadow Z array, round-robin order, expected latency and pass count).
module tb_zbuf_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic [15:0] pass_cnt;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  ram  [65536];
  logic [7:0]  zref [65536];
  int          last_srv = 2;
  int unsigned cnt_ref = 0;

  zbuf_arbiter_if #(.COORD_W(8), .Z_W(8)) bus ();

  zbuf_arbiter #(.COORD_W(8), .Z_W(8), .Z_MAX(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .pass_cnt (pass_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] addr_of(input logic [23:0] p);
    return {p[15:8], p[23:16]};
  endfunction

  // Depth test rule: strictly nearer z replaces the stored depth
  task automatic frag(input logic [23:0] p, output bit pass);
    logic [15:0] a;
    a = addr_of(p);
    pass = p[7:0] < zref[a];
    if (pass) begin
      zref[a] = p[7:0];
      if (cnt_ref < 32'd65535) cnt_ref++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req_1 = 1'b0;
    bus.req_2 = 1'b0;
    clr_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_srv = 2;
    cnt_ref = 0;
  endtask

  task automatic txn(input bit r1, input bit r2, input logic [23:0] p1, input logic [23:0] p2);
    int first, first_ack, lat, rd_cnt, wr_cnt, both;
    bit ps1, ps2, done1, done2, fin, got_rd;
    logic [15:0] rd_addr;
    first = (r1 && r2) ? ((last_srv == 2) ? 1 : 2) : (r1 ? 1 : 2);
    ps1 = 1'b0; ps2 = 1'b0;
    if (first == 1) begin
      frag(p1, ps1);
      if (r2) frag(p2, ps2);
    end else begin
      frag(p2, ps2);
      if (r1) frag(p1, ps1);
    end
    last_srv = (r1 && r2) ? (3 - first) : first;
    first_ack = 0; lat = 0; rd_cnt = 0; wr_cnt = 0; both = 0;
    fin = 1'b0; got_rd = 1'b0; rd_addr = '0;
    done1 = !r1; done2 = !r2;
    bus.pt_1 = p1; bus.pt_2 = p2;
    bus.req_1 = r1; bus.req_2 = r2;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (bus.mem_rd) begin
        rd_cnt++;
        if (!got_rd) begin got_rd = 1'b1; rd_addr = bus.mem_addr; end
      end
      if (bus.mem_wr) wr_cnt++;
      if (bus.mem_rd && bus.mem_wr) both++;
      if (bus.ack_1 && bus.req_1) begin
        if (first_ack == 0) begin first_ack = 1; lat = t - 1; end
        check("pass_1", 32'(bus.pass_1), 32'(ps1));
        bus.req_1 = 1'b0; done1 = 1'b1;
      end
      if (bus.ack_2 && bus.req_2) begin
        if (first_ack == 0) begin first_ack = 2; lat = t - 1; end
        check("pass_2", 32'(bus.pass_2), 32'(ps2));
        bus.req_2 = 1'b0; done2 = 1'b1;
      end
      if (done1 && done2 && !bus.ack_1 && !bus.ack_2) begin fin = 1'b1; break; end
    end
    check("txn_done", 32'(fin), 32'd1);
    check("order", 32'(first_ack), 32'(first));
    check("latency", 32'(lat), ((first == 1) ? ps1 : ps2) ? 32'd4 : 32'd3);
    check("rd_addr", 32'(rd_addr), 32'(addr_of(first == 1 ? p1 : p2)));
    check("rd_cnt", 32'(rd_cnt), 32'(int'(r1) + int'(r2)));
    check("wr_cnt", 32'(wr_cnt), 32'(int'(r1 && ps1) + int'(r2 && ps2)));
    check("rd_wr_excl", 32'(both), 32'd0);
    check("pass_cnt", 32'(pass_cnt), cnt_ref);
    bus.req_1 = 1'b0; bus.req_2 = 1'b0;
  endtask

  initial begin
    int bad, n;
    bit ps, seen;
    logic [23:0] p1, p2;
    logic [1:0] r;
    bus.req_1 = 1'b0; bus.req_2 = 1'b0;
    bus.pt_1 = '0; bus.pt_2 = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl", 32'({bus.ack_1, bus.pass_1, bus.ack_2, bus.pass_2,
                          bus.mem_rd, bus.mem_wr, clr_busy}), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_cnt", 32'(pass_cnt), 32'd0);
    rst = 1'b1;

    // Full clear; a second clr_start pulse lands mid-clear and must be ignored
    @(negedge clk); clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0;
    check("clr_pending", 32'({clr_busy, bus.mem_wr}), 32'b10);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 65536; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 16'(i) ||
          bus.mem_wdata !== 8'hFF || clr_busy !== 1'b1) bad++;
      if (i == 30000) clr_start = 1'b1;
      if (i == 30001) clr_start = 1'b0;
    end
    check("clr_writes", 32'(bad), 32'd0);
    @(negedge clk);
    check("clr_end", 32'({clr_busy, bus.mem_wr}), 32'd0);
    repeat (5) @(negedge clk);
    check("clr_no_rerun", 32'({clr_busy, bus.mem_wr}), 32'd0);
    n = 0;
    for (int i = 0; i < 65536; i++) begin
      if (ram[i] !== 8'hFF) n++;
      zref[i] = 8'hFF;
    end
    check("clr_contents", 32'(n), 32'd0);

    txn(1'b1, 1'b0, 24'h013201, 24'h0);
    check("ram_3201", 32'(ram[16'h3201]), 32'h01);
    txn(1'b0, 1'b1, 24'h0, 24'h013205);
    txn(1'b0, 1'b1, 24'h0, 24'h013201);
    check("ram_3201_kept", 32'(ram[16'h3201]), 32'h01);

    do_reset();
    txn(1'b1, 1'b1, 24'h020240, 24'h030350);
    txn(1'b1, 1'b0, 24'h020230, 24'h0);
    txn(1'b1, 1'b1, 24'h020220, 24'h030310);

    for (int k = 0; k < 150; k++) begin
      r  = 2'($urandom_range(1, 3));
      p1 = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom)};
      p2 = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom)};
      txn(r[0], r[1], p1, p2);
    end

    // Clear requested during RD: the current handshake finishes, then CLR beats req_2
    p1 = 24'hA1A010;
    frag(p1, ps);
    bus.pt_1 = p1; bus.req_1 = 1'b1;
    @(negedge clk);
    check("t5_in_rd", 32'(bus.mem_rd), 32'd1);
    clr_start = 1'b1;
    bus.pt_2 = 24'hA2A011; bus.req_2 = 1'b1;
    @(negedge clk); clr_start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (bus.ack_1) begin
        seen = 1'b1;
        check("t5_pass_1", 32'(bus.pass_1), 32'(ps));
        check("t5_busy_in_ack", 32'(clr_busy), 32'd1);
        bus.req_1 = 1'b0;
      end else @(negedge clk);
    end
    check("t5_ack_1", 32'(seen), 32'd1);
    seen = 1'b0; bad = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (bus.ack_2) bad++;
      if (bus.mem_wr && clr_busy && bus.mem_addr == 16'h0000 && bus.mem_wdata == 8'hFF) seen = 1'b1;
    end
    check("t5_clr_start", 32'(seen), 32'd1);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.ack_2 || bus.mem_rd || !bus.mem_wr) bad++;
    end
    check("t5_req_2_held", 32'(bad), 32'd0);
    do_reset();

    // Reset while WR is on the bus must suppress the write
    txn(1'b1, 1'b0, 24'hB1B120, 24'h0);
    p1 = 24'hB2B320;
    bus.pt_1 = p1; bus.req_1 = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (bus.mem_wr) seen = 1'b1;
    end
    check("t6_reach_wr", 32'(seen), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_async_ctl", 32'({bus.ack_1, bus.pass_1, bus.mem_rd, bus.mem_wr, clr_busy}), 32'd0);
    check("t6_async_addr", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
    check("t6_async_cnt", 32'(pass_cnt), 32'd0);
    bus.req_1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_srv = 2;
    cnt_ref = 0;
    txn(1'b1, 1'b0, p1, 24'h0);
    check("t6_ram", 32'(ram[addr_of(p1)]), 32'(zref[addr_of(p1)]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
